fpu_div: RTL and testbench

//  Iterative IEEE 754 single-precision divider: result = a / b. Companion to the

---
 rtl/fpu_div.sv | 131 +++++++++++++
 tb/tb_fpu_div.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fpu_div.sv
// Iterative binary32 divider: one restoring quotient bit per clock, truncating, no subnormals.
// Special operands finish on the accepting edge; the normal path takes 25 DIV cycles.
module fpu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] result_q, result_d;
  logic [24:0] rem_q, rem_d;
  logic [24:0] q_q, q_d;
  logic [23:0] mb_q, mb_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;

  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] q_next;
  logic signed [9:0] exp_s;
  logic [22:0] mant_n;

  // Exponent 0 covers both true zero and subnormals, which are flushed to zero.
  assign a_zero = (a[30:23] == 8'h00);
  assign b_zero = (b[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign q_next  = q_q | ({24'd0, rem_ge} << cnt_q);

  // Normalisation works on the quotient including the bit decided this cycle.
  assign exp_s  = $signed({2'b00, ea_q} - {2'b00, eb_q} + (q_next[24] ? 10'd127 : 10'd126));
  assign mant_n = q_next[24] ? q_next[23:1] : q_next[22:0];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    q_d      = q_q;
    mb_d     = mb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d = a[31] ^ b[31];
          ea_d  = a[30:23];
          eb_d  = b[30:23];
          mb_d  = {1'b1, b[22:0]};
          rem_d = {2'b01, a[22:0]};
          q_d   = 25'd0;
          cnt_d = 5'd24;
          state_d = S_DONE;
          if (a_nan || b_nan)
            result_d = 32'h7FC00000;
          else if ((a_inf && b_inf) || (a_zero && b_zero))
            result_d = 32'h7FC00000;
          else if (a_inf || b_zero)
            result_d = {a[31] ^ b[31], 8'hFF, 23'd0};
          else if (a_zero || b_inf)
            result_d = {a[31] ^ b[31], 31'd0};
          else
            state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_sub << 1;
        q_d   = q_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          if (exp_s >= 10'sd255)
            result_d = {sgn_q, 8'hFF, 23'd0};
          else if (exp_s <= 10'sd0)
            result_d = {sgn_q, 31'd0};
          else
            result_d = {sgn_q, exp_s[7:0], mant_n};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= 32'd0;
      rem_q    <= 25'd0;
      q_q      <= 25'd0;
      mb_q     <= 24'd0;
      ea_q     <= 8'd0;
      eb_q     <= 8'd0;
      cnt_q    <= 5'd0;
      sgn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      mb_q     <= mb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      cnt_q    <= cnt_d;
      sgn_q    <= sgn_d;
    end
  end

  assign busy   = (state_q == S_DIV);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_fpu_div.sv
// Directed bench for fpu_div: hand-computed quotients, specials, range limits and control cases.
module tb_fpu_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  fpu_div dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one operation; glitch pulses start with other operands while busy.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [31:0] exp_res, input int exp_busy, input int exp_lat,
                        input bit glitch);
    int busy_n;
    int lat;
    busy_n = 0;
    lat    = -1;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (glitch && n == 4) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      end
      if (glitch && n == 6) start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_n++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, " result"}, result, exp_res);
    @(negedge clk);
    check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 25, 25, 1'b0);
    repeat (3) @(negedge clk);
    check("6/2 result held", result, 32'h40400000);
    run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 25, 25, 1'b0);
    run_op("-1/4",     32'hBF800000, 32'h40800000, 32'hBE800000, 25, 25, 1'b0);
    run_op("2/-3",     32'h40000000, 32'hC0400000, 32'hBF2AAAAA, 25, 25, 1'b0);
    run_op("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 1'b0);
    run_op("0/0",      32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 1'b0);
    run_op("nan/1",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0, 1'b0);
    run_op("inf/inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 0, 0, 1'b0);
    run_op("-inf/2",   32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 1'b0);
    run_op("0/-1",     32'h00000000, 32'hBF800000, 32'h80000000, 0, 0, 1'b0);
    run_op("3/inf",    32'h40400000, 32'h7F800000, 32'h00000000, 0, 0, 1'b0);
    run_op("sub/1",    32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 1'b0);
    run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 25, 25, 1'b0);
    run_op("underflow",32'h00800000, 32'h7F000000, 32'h00000000, 25, 25, 1'b0);
    run_op("glitch",   32'h40C00000, 32'h40000000, 32'h40400000, 25, 25, 1'b1);

    // Abandon an operation mid-flight with reset.
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst no done", 32'(done_seen), 32'd0);
    run_op("after rst", 32'hBF800000, 32'h40800000, 32'hBE800000, 25, 25, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
